// File: rtl/branch_ctrl.sv
// B-type branch sequencer: captures an instruction, reads rs1/rs2 over a handshaked RF port,
// evaluates the condition and returns taken/target. Define BRANCH_STATS_EN for taken/not-taken counters.
module branch_ctrl #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instruction_word,
  input  logic [XLEN-1:0] pc,
  output logic            rf_req,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  input  logic            rf_ack,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_taken,
  output logic [XLEN-1:0] resp_target,
  output logic            resp_illegal,
`ifdef BRANCH_STATS_EN
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_not_taken,
`endif
  output logic [1:0]      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the offering side holds its payload stable while valid is high and ready is low.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RF_WAIT = 2'd1;
  localparam logic [1:0] EXEC    = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [31:0]     iw_q, iw_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            illegal_q, illegal_d;

  logic            in_illegal;
  logic [XLEN-1:0] imm;
  logic            cond;

  assign in_illegal = (instruction_word[6:0] != 7'b1100011) ||
                      (instruction_word[14:12] == 3'b010) ||
                      (instruction_word[14:12] == 3'b011);

  assign imm = {{(XLEN-12){iw_q[31]}}, iw_q[7], iw_q[30:25], iw_q[11:8], 1'b0};

  always_comb begin
    cond = 1'b0;
    case (iw_q[14:12])
      3'b000:  cond = (rs1_q == rs2_q);
      3'b001:  cond = (rs1_q != rs2_q);
      3'b100:  cond = ($signed(rs1_q) <  $signed(rs2_q));
      3'b101:  cond = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  cond = (rs1_q <  rs2_q);
      3'b111:  cond = (rs1_q >= rs2_q);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    iw_d      = iw_q;
    pc_d      = pc_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    taken_d   = taken_q;
    target_d  = target_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          iw_d = instruction_word;
          pc_d = pc;
          if (in_illegal) begin
            state_d   = RESP;
            illegal_d = 1'b1;
            taken_d   = 1'b0;
            target_d  = '0;
          end else begin
            state_d   = RF_WAIT;
            illegal_d = 1'b0;
          end
        end
      end
      RF_WAIT: begin
        if (rf_ack) begin
          rs1_d   = rf_rs1_data;
          rs2_d   = rf_rs2_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        taken_d  = cond;
        target_d = pc_q + imm;
        state_d  = RESP;
      end
      default: begin
        if (resp_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      iw_q      <= '0;
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      taken_q   <= 1'b0;
      target_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      iw_q      <= iw_d;
      pc_q      <= pc_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
      illegal_q <= illegal_d;
    end
  end

  // instr_ready is gated by rst_n so it reads 0 while reset is asserted.
  assign instr_ready  = rst_n && (state_q == IDLE);
  assign rf_req       = (state_q == RF_WAIT);
  assign rf_rs1_addr  = iw_q[19:15];
  assign rf_rs2_addr  = iw_q[24:20];
  assign resp_valid   = (state_q == RESP);
  assign resp_taken   = taken_q;
  assign resp_target  = target_q;
  assign resp_illegal = illegal_q;
  assign dbg_state    = state_q;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_taken_q, stat_taken_d;
  logic [STAT_W-1:0] stat_not_taken_q, stat_not_taken_d;
  logic              count_en;

  assign count_en = (state_q == RESP) && resp_ready && !illegal_q;

  always_comb begin
    stat_taken_d     = stat_taken_q;
    stat_not_taken_d = stat_not_taken_q;
    if (count_en && taken_q && (stat_taken_q != {STAT_W{1'b1}}))
      stat_taken_d = stat_taken_q + 1'b1;
    if (count_en && !taken_q && (stat_not_taken_q != {STAT_W{1'b1}}))
      stat_not_taken_d = stat_not_taken_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken_q     <= '0;
      stat_not_taken_q <= '0;
    end else begin
      stat_taken_q     <= stat_taken_d;
      stat_not_taken_q <= stat_not_taken_d;
    end
  end

  assign stat_taken     = stat_taken_q;
  assign stat_not_taken = stat_not_taken_q;
`else
  localparam int unused_stat_w = STAT_W;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized bench for branch_ctrl against a field-level reference model of B-type branches.
module tb_branch_ctrl;

`ifdef BRANCH_STATS_EN
  localparam int TB_STAT_W = 2;
`else
  localparam int TB_STAT_W = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instruction_word = '0;
  logic [31:0] pc = '0;
  logic        rf_req;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic        rf_ack = 1'b0;
  logic [31:0] rf_rs1_data = '0, rf_rs2_data = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_taken;
  logic [31:0] resp_target;
  logic        resp_illegal;
  logic [1:0]  dbg_state;
`ifdef BRANCH_STATS_EN
  logic [TB_STAT_W-1:0] stat_taken, stat_not_taken;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic [33:0] exp_q[$];
  logic        last_taken;
  logic [31:0] last_target;
  int          cnt_taken = 0;
  int          cnt_not_taken = 0;

  branch_ctrl #(.XLEN(32), .STAT_W(TB_STAT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction_word(instruction_word), .pc(pc),
    .rf_req(rf_req), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_ack(rf_ack), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_taken(resp_taken), .resp_target(resp_target), .resp_illegal(resp_illegal),
`ifdef BRANCH_STATS_EN
    .stat_taken(stat_taken), .stat_not_taken(stat_not_taken),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] ref_model(input logic [31:0] iw, input logic [31:0] pcv,
                                            input logic [31:0] a, input logic [31:0] b);
    int imm;
    logic tk;
    logic [31:0] tgt;
    if (iw[6:0] != 7'b1100011 || iw[14:12] == 3'd2 || iw[14:12] == 3'd3)
      return {2'b10, 32'h0};
    imm = (iw[31] ? -4096 : 0) + int'(iw[7]) * 2048 + int'(iw[30:25]) * 32 + int'(iw[11:8]) * 2;
    tgt = pcv + imm;
    case (iw[14:12])
      3'd0:    tk = (a == b);
      3'd1:    tk = (a != b);
      3'd4:    tk = ($signed(a) <  $signed(b));
      3'd5:    tk = ($signed(a) >= $signed(b));
      3'd6:    tk = (a <  b);
      default: tk = (a >= b);
    endcase
    return {1'b0, tk, tgt};
  endfunction

  function automatic int sat(input int v);
    int mx;
    mx = (1 << TB_STAT_W) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr_ready"}, instr_ready, 0);
    check({tag, "_rf_req"}, rf_req, 0);
    check({tag, "_rs1_addr"}, rf_rs1_addr, 0);
    check({tag, "_rs2_addr"}, rf_rs2_addr, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_taken"}, resp_taken, 0);
    check({tag, "_resp_target"}, resp_target, 0);
    check({tag, "_resp_illegal"}, resp_illegal, 0);
`ifdef BRANCH_STATS_EN
    check({tag, "_stat_taken"}, stat_taken, 0);
    check({tag, "_stat_not_taken"}, stat_not_taken, 0);
`endif
  endtask

  // driver: one complete branch, entered and left at a negedge with the DUT idle
  task automatic drive_branch(input logic [31:0] iw, input logic [31:0] pcv,
                              input logic [31:0] a, input logic [31:0] b,
                              input int ack_dly, input int rdy_dly);
    logic [33:0] exp;
    logic [33:0] got;
    exp_q.push_back(ref_model(iw, pcv, a, b));
    check("instr_ready_idle", instr_ready, 1);
    instr_valid = 1'b1;
    instruction_word = iw;
    pc = pcv;
    @(negedge clk);
    instr_valid = 1'b0;
    instruction_word = $urandom;
    pc = $urandom;
    exp = exp_q.pop_front();
    if (!exp[33]) begin
      for (int i = 0; i <= ack_dly; i++) begin
        check("rf_req_wait", rf_req, 1);
        check("rs1_addr", rf_rs1_addr, iw[19:15]);
        check("rs2_addr", rf_rs2_addr, iw[24:20]);
        check("instr_ready_busy", instr_ready, 0);
        check("resp_valid_early", resp_valid, 0);
        rf_ack = (i == ack_dly);
        rf_rs1_data = (i == ack_dly) ? a : $urandom;
        rf_rs2_data = (i == ack_dly) ? b : $urandom;
        @(negedge clk);
      end
      rf_ack = 1'b0;
      rf_rs1_data = $urandom;
      rf_rs2_data = $urandom;
      check("rf_req_drop", rf_req, 0);
      check("resp_valid_exec", resp_valid, 0);
      @(negedge clk);
    end else begin
      check("rf_req_illegal", rf_req, 0);
    end
    check("resp_valid", resp_valid, 1);
    check("resp_illegal", resp_illegal, exp[33]);
    check("resp_taken", resp_taken, exp[32]);
    check("resp_target", resp_target, exp[31:0]);
    got = {resp_illegal, resp_taken, resp_target};
    for (int i = 0; i < rdy_dly; i++) begin
      rf_ack = 1'($urandom_range(0, 1));
      rf_rs1_data = $urandom;
      rf_rs2_data = $urandom;
      @(negedge clk);
      check("resp_valid_hold", resp_valid, 1);
      check("resp_target_hold", resp_target, got[31:0]);
      check("resp_flags_hold", {resp_illegal, resp_taken}, got[33:32]);
      check("instr_ready_resp", instr_ready, 0);
      check("rf_req_resp", rf_req, 0);
    end
    rf_ack = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_valid_done", resp_valid, 0);
    check("instr_ready_after", instr_ready, 1);
    if (!exp[33]) begin
      if (exp[32]) cnt_taken++;
      else cnt_not_taken++;
    end
`ifdef BRANCH_STATS_EN
    check("stat_taken", stat_taken, sat(cnt_taken));
    check("stat_not_taken", stat_not_taken, sat(cnt_not_taken));
`endif
    last_taken = got[32];
    last_target = got[31:0];
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    cnt_taken = 0;
    cnt_not_taken = 0;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] iw, a, b;
    logic [2:0] legal_f3 [6];
    legal_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    #2;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // BGEU x13,x21 with equal values, minimum latency
    drive_branch(32'b0000111_10101_01101_111_01101_1100011, 32'h1000, 32'd5, 32'd5, 0, 0);
    check("t1_taken", last_taken, 1);
    check("t1_target", last_target, 32'h18EC);

    // BLT signed vs BLTU on the same operands
    drive_branch(32'b1010101_11100_00110_100_11101_1100011, 32'h2000, 32'hFFFF_FFFF, 32'd1, 0, 0);
    check("blt_taken", last_taken, 1);
    check("blt_target", last_target, 32'h1ABC);
    drive_branch(32'b1010101_11100_00110_110_11101_1100011, 32'h2000, 32'hFFFF_FFFF, 32'd1, 0, 0);
    check("bltu_taken", last_taken, 0);

    // illegal funct3 and illegal opcode
    drive_branch(32'b0000111_10101_01101_010_01101_1100011, 32'h3000, 32'd1, 32'd1, 0, 1);
    drive_branch(32'b0000000_00010_00001_000_00011_0110011, 32'h3004, 32'd1, 32'd1, 0, 0);

    // slow register file and slow consumer
    drive_branch(32'b0000111_10101_01101_001_01101_1100011, 32'h4000, 32'd7, 32'd9, 5, 3);

    // target wraps past 2^32
    drive_branch(32'b0000001_00010_00001_000_00000_1100011, 32'hFFFF_FFF0, 32'd3, 32'd3, 0, 0);
    check("wrap_target", last_target, 32'h0000_0010);

    // reset during RF_WAIT discards the branch
    check("pre_rst_ready", instr_ready, 1);
    instr_valid = 1'b1;
    instruction_word = 32'b0000111_10101_01101_000_01101_1100011;
    pc = 32'h5000;
    @(negedge clk);
    instr_valid = 1'b0;
    check("pre_rst_rf_req", rf_req, 1);
    rst_n = 1'b0;
    #1;
    cnt_taken = 0;
    cnt_not_taken = 0;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_branch(32'b0000111_10101_01101_101_01101_1100011, 32'h6000, 32'h8000_0000, 32'd0, 1, 1);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      iw = $urandom;
      iw[14:12] = legal_f3[$urandom_range(0, 5)];
      iw[6:0] = 7'b1100011;
      if ($urandom_range(0, 7) == 0) iw[14:12] = 3'($urandom_range(2, 3));
      if ($urandom_range(0, 9) == 0) iw[6:0] = 7'($urandom_range(0, 98));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = ~a;
        2: b = a + 32'($urandom_range(0, 2)) - 32'd1;
        default: b = $urandom;
      endcase
      drive_branch(iw, $urandom, a, b, $urandom_range(0, 4), $urandom_range(0, 3));
    end

`ifdef BRANCH_STATS_EN
    // taken counter saturates
    @(negedge clk);
    apply_reset();
    for (int n = 0; n < 5; n++)
      drive_branch(32'b0000000_00010_00001_000_01000_1100011, 32'h100, 32'd4, 32'd4, 0, 0);
    check("sat_taken", stat_taken, 3);
    check("sat_not_taken", stat_not_taken, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Sequencing controller for B-type (conditional branch) instructions. It accepts a decoded-ready 32-bit instruction word and its PC, and splits out rs1, rs2, funct3 and the 13-bit branch immediate. It then reads both source registers through a handshaked register-file read port, evaluates the branch condition and returns a taken flag with a redirect target. It sits between the instruction decoder and the PC/fetch logic and owns the register-file read port for the duration of each branch.

## Interface
Parameters:
- XLEN, 32, datapath width (instruction, PC and register data)
- STAT_W, 16, width of statistics counters (only with BRANCH_STATS_EN)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- instr_valid  input  1  instruction offered
- instr_ready  output  1  controller can accept (high only in IDLE)
- instruction_word  input  32  instruction
- pc  input  XLEN  PC of instruction
- rf_req  output  1  register-file read request
- rf_rs1_addr  output  5  rs1 index (instruction_word[19:15])
- rf_rs2_addr  output  5  rs2 index (instruction_word[24:20])
- rf_ack  input  1  read data valid this cycle
- rf_rs1_data  input  XLEN  rs1 value
- rf_rs2_data  input  XLEN  rs2 value
- resp_valid  output  1  result valid
- resp_ready  input  1  consumer accepts result
- resp_taken  output  1  branch taken
- resp_target  output  XLEN  pc + sign-extended immediate
- resp_illegal  output  1  opcode not 1100011 or funct3 in {010,011}
- stat_taken, stat_not_taken  output  STAT_W  counters (BRANCH_STATS_EN only)

## Operation
- States: IDLE, RF_WAIT, EXEC, RESP.
- IDLE: instr_ready=1. On instr_valid, capture instruction_word and pc. Legal opcode/funct3 -> RF_WAIT; illegal -> RESP with resp_illegal=1, resp_taken=0, resp_target=0, no rf_req.
- RF_WAIT: rf_req=1, addresses stable from captured word. On rf_ack, capture both data words -> EXEC. rf_req drops the cycle after ack.
- EXEC: one cycle. Immediate = sext({iw[31], iw[7], iw[30:25], iw[11:8], 1'b0}). Target = pc + imm, modulo 2^XLEN (wraps, no flag). Conditions by funct3: 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU. -> RESP.
- RESP: resp_valid=1, resp_* held stable until resp_valid && resp_ready -> IDLE.
- rs1 = rs2 = x0 is not special-cased; values come from the register file.

## Timing
- Reset values: instr_ready=0 during reset and 1 in IDLE afterwards. rf_req=0, rf_rs1_addr=0, rf_rs2_addr=0, resp_valid=0, resp_taken=0, resp_target=0, resp_illegal=0, counters=0.
- Minimum legal latency: accept at edge 0; rf_req high in cycle 1; ack in cycle 1 -> EXEC in cycle 2 -> resp_valid in cycle 3.
- Illegal latency: resp_valid in the cycle after accept.
- rf_ack is ignored outside RF_WAIT. Wait states on rf_ack are unbounded.
- No new instruction is accepted in the cycle of resp handshake; IDLE is reached on the following cycle.
- rst_n low mid-operation: immediate return to IDLE with all outputs at reset values. An in-flight branch is discarded.

## Configuration
- BRANCH_STATS_EN defined: stat_taken and stat_not_taken increment by 1 on each legal resp handshake and saturate at 2^STAT_W-1. Illegal responses are not counted.
- Undefined: stat ports and counters are absent; behaviour is otherwise identical.

## Test plan
- 32'b0000111_10101_01101_111_01101_1100011, pc=0x1000, rs1(x13)=5, rs2(x21)=5, ack cycle 1 -> rf addrs 13/21, BGEU taken=1, target=0x18EC, resp_valid in cycle 3.
- 32'b1010101_11100_00110_100_11101_1100011, pc=0x2000, x6=0xFFFFFFFF, x28=1 -> BLT signed taken=1, target=0x1ABC. Repeat as BLTU (funct3 110) -> taken=0.
- funct3=010 or opcode 0110011 -> resp_illegal=1, taken=0, rf_req never asserted, resp_valid in the cycle after accept.
- rf_ack delayed 5 cycles and resp_ready low 3 cycles -> rf_req held 6 cycles and resp outputs stable until handshake. instr_ready stays 0 throughout.
- pc=0xFFFFFFF0 with imm=+0x20 -> target=0x00000010 (wrap). rst_n pulsed low during RF_WAIT -> all outputs reset and the next instruction is processed normally.
- BRANCH_STATS_EN with STAT_W=2: 5 taken branches -> stat_taken=3 (saturated), stat_not_taken=0.
